// File: rtl/controle_jogo_pkg.sv
// Shared types and constants for the game controller: state codes, hint codes, password widths.
package jogo_pkg;

   localparam int WA = 4;
   localparam int WB = 3;

   typedef enum logic [2:0] {
      CARREGA_A  = 3'd0,
      CARREGA_B  = 3'd1,
      ADIVINHA_A = 3'd2,
      AVALIA_A   = 3'd3,
      ADIVINHA_B = 3'd4,
      AVALIA_B   = 3'd5,
      VITORIA    = 3'd6,
      DERROTA    = 3'd7
   } estado_t;

   localparam logic [1:0] COMP_MENOR = 2'b00;
   localparam logic [1:0] COMP_MAIOR = 2'b01;
   localparam logic [1:0] COMP_IGUAL = 2'b10;

endpackage

// File: rtl/controle_jogo_if.sv
// Bundle between the game controller (slave) and its surroundings: switches, button, hint stage, display.
interface controle_jogo_if;
   import jogo_pkg::*;

   logic [WA-1:0] chaves;
   logic          confirma;
   logic [1:0]    comp;
   logic [WA-1:0] senhaA;
   logic [WB-1:0] senhaB;
   logic [WA-1:0] tentativaA;
   logic [WB-1:0] tentativaB;
   logic          modoB;
   logic [2:0]    fase;
   logic [3:0]    restantes;
   logic [1:0]    ultimo_comp;
   logic          dica_valida;
   logic          venceu;
   logic          perdeu;

   modport master (
      output chaves, confirma, comp,
      input  senhaA, senhaB, tentativaA, tentativaB, modoB, fase,
             restantes, ultimo_comp, dica_valida, venceu, perdeu
   );

   modport slave (
      input  chaves, confirma, comp,
      output senhaA, senhaB, tentativaA, tentativaB, modoB, fase,
             restantes, ultimo_comp, dica_valida, venceu, perdeu
   );
endinterface

// File: rtl/controle_jogo_borda.sv
// Rising-edge detector: one-cycle pulse per low-to-high transition; synchronous active-high reset.
module detector_borda (
   input  logic clk,
   input  logic rst,
   input  logic sinal_i,
   output logic pulso_o
);

   logic sinal_q;

   always_ff @(posedge clk) begin
      if (rst) sinal_q <= 1'b0;
      else     sinal_q <= sinal_i;
   end

   assign pulso_o = sinal_i & ~sinal_q;

endmodule

// File: rtl/controle_jogo.sv
// Game-control FSM: loads passwords A/B, captures guesses, evaluates hint result, tracks attempts, win/loss.
module controle_jogo
   import jogo_pkg::*;
#(
   parameter int MAX_TENT = 8
) (
   input  logic           clk,
   input  logic           rst,
   controle_jogo_if.slave jogo
);

   localparam logic [3:0] TENT_INI = 4'(MAX_TENT);

   estado_t       estado_q;
   logic [WA-1:0] senhaA_q;
   logic [WB-1:0] senhaB_q;
   logic [WA-1:0] tentativaA_q;
   logic [WB-1:0] tentativaB_q;
   logic          modoB_q;
   logic [3:0]    restantes_q;
   logic [3:0]    restantes_d;
   logic [1:0]    ultimo_comp_q;
   logic          dica_valida_q;
   logic          venceu_q;
   logic          perdeu_q;
   logic          pulso;
   logic          novo_jogo;

   detector_borda u_borda (
      .clk     (clk),
      .rst     (rst),
      .sinal_i (jogo.confirma),
      .pulso_o (pulso)
   );

   // Saturating decrement keeps restantes from wrapping even on an unexpected path.
   assign restantes_d = (restantes_q != 4'd0) ? restantes_q - 4'd1 : 4'd0;
   assign novo_jogo   = pulso && (estado_q == VITORIA || estado_q == DERROTA);

   always_ff @(posedge clk) begin
      if (rst || novo_jogo) begin
         estado_q      <= CARREGA_A;
         senhaA_q      <= '0;
         senhaB_q      <= '0;
         tentativaA_q  <= '0;
         tentativaB_q  <= '0;
         modoB_q       <= 1'b0;
         restantes_q   <= TENT_INI;
         ultimo_comp_q <= 2'b00;
         dica_valida_q <= 1'b0;
         venceu_q      <= 1'b0;
         perdeu_q      <= 1'b0;
      end else begin
         case (estado_q)
            CARREGA_A: if (pulso) begin
               senhaA_q <= jogo.chaves;
               estado_q <= CARREGA_B;
            end
            CARREGA_B: if (pulso) begin
               senhaB_q <= jogo.chaves[WB-1:0];
               estado_q <= ADIVINHA_A;
            end
            ADIVINHA_A: if (pulso) begin
               tentativaA_q <= jogo.chaves;
               estado_q     <= AVALIA_A;
            end
            ADIVINHA_B: if (pulso) begin
               tentativaB_q <= jogo.chaves[WB-1:0];
               estado_q     <= AVALIA_B;
            end
            AVALIA_A, AVALIA_B: begin
               ultimo_comp_q <= jogo.comp;
               dica_valida_q <= 1'b1;
               if (jogo.comp == COMP_IGUAL) begin
                  if (estado_q == AVALIA_A) begin
                     modoB_q       <= 1'b1;
                     dica_valida_q <= 1'b0;
                     estado_q      <= ADIVINHA_B;
                  end else begin
                     venceu_q <= 1'b1;
                     estado_q <= VITORIA;
                  end
               end else begin
                  // Anything but IGUAL, including the illegal 11 code, costs an attempt.
                  restantes_q <= restantes_d;
                  if (restantes_q <= 4'd1) begin
                     perdeu_q <= 1'b1;
                     estado_q <= DERROTA;
                  end else begin
                     estado_q <= (estado_q == AVALIA_A) ? ADIVINHA_A : ADIVINHA_B;
                  end
               end
            end
            VITORIA, DERROTA: ;
            default: estado_q <= CARREGA_A;
         endcase
      end
   end

   assign jogo.senhaA      = senhaA_q;
   assign jogo.senhaB      = senhaB_q;
   assign jogo.tentativaA  = tentativaA_q;
   assign jogo.tentativaB  = tentativaB_q;
   assign jogo.modoB       = modoB_q;
   assign jogo.fase        = estado_q;
   assign jogo.restantes   = restantes_q;
   assign jogo.ultimo_comp = ultimo_comp_q;
   assign jogo.dica_valida = dica_valida_q;
   assign jogo.venceu      = venceu_q;
   assign jogo.perdeu      = perdeu_q;

endmodule
